// File: rtl/led_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_out_pkg
// Description : Shared types and defaults for the serial LED output stage.
//               Holds the shifter FSM state encoding and the default frame
//               width / shift-clock divider used by led_shift_out.
// Revision    : 1.0 - initial release
// ============================================================================
package led_out_pkg;

    // Default frame geometry: 16 LEDs, 4 clk cycles per shift-clock half-period
    localparam int LED_WIDTH_DEFAULT   = 16;
    localparam int LED_CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } led_state_t;

endpackage
`default_nettype wire

// File: rtl/led_shift_tick.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_tick
// Description : Modulo-CLK_DIV counter with synchronous clear. Raises tick on
//               the last clk cycle of each shift-clock half-period.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               clear - synchronous clear; holds the count at zero
//               tick  - high on the last cycle of a half-period
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear || (div_cnt == LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Suppressed while cleared so a held-idle counter never reports a tick
    assign tick = !clear && (div_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/led_shift_out.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_out
// Description : Serialises a parallel LED word into a daisy-chained 74HC595
//               string (serial data, shift clock, latch clock). A frame is
//               sent once after reset and whenever leds differs from the last
//               word transmitted. MSB is shifted out first.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               leds       - parallel LED word (WIDTH bits)
//               ser        - serial data to 595 DS
//               srclk      - shift clock to 595 SHCP
//               rclk       - latch clock to 595 STCP
//               busy       - high while a frame is in flight
//               frame_done - one-cycle pulse after the latch pulse
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_out
    import led_out_pkg::*;
#(
    parameter int WIDTH   = LED_WIDTH_DEFAULT,
    parameter int CLK_DIV = LED_CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] leds,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             busy,
    output logic             frame_done
);

    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    led_state_t       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] shadow, shadow_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic             first, first_nx;
    logic             frame_done_nx;
    logic             tick;

    // Divider is held at zero in IDLE so each frame starts on a full half-period
    led_shift_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        shadow_nx     = shadow;
        bit_cnt_nx    = bit_cnt;
        first_nx      = first;
        frame_done_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (first || (leds != shadow)) begin
                    shreg_nx   = leds;
                    shadow_nx  = leds;
                    first_nx   = 1'b0;
                    bit_cnt_nx = '0;
                    state_nx   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_nx = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    shreg_nx = shreg << 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = ST_LATCH;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                        state_nx   = ST_LOW;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_nx      = ST_IDLE;
                    frame_done_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state register rather than trailing it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            shadow     <= '0;
            bit_cnt    <= '0;
            first      <= 1'b1;
            ser        <= 1'b0;
            srclk      <= 1'b0;
            rclk       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            shadow     <= shadow_nx;
            bit_cnt    <= bit_cnt_nx;
            first      <= first_nx;
            // shreg only shifts on HIGH exit, so ser is stable across the
            // whole LOW/HIGH pair for each bit.
            ser        <= ((state_nx == ST_LOW) || (state_nx == ST_HIGH)) ?
                          shreg_nx[WIDTH-1] : 1'b0;
            srclk      <= (state_nx == ST_HIGH);
            rclk       <= (state_nx == ST_LATCH);
            busy       <= (state_nx != ST_IDLE);
            frame_done <= frame_done_nx;
        end
    end

endmodule
`default_nettype wire
